// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: op encodings,
// command byte bit positions and the sequencer state encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_t;

    localparam int CMD_OP_LSB    = 0;
    localparam int CMD_OP_MSB    = 2;
    localparam int CMD_CHAIN_BIT = 3;
    localparam int CMD_UNARY_BIT = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_GET_B = 3'd2,
        S_EXEC  = 3'd3,
        S_RESP  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: collects a command byte and up to two operand
// bytes from a valid/ready stream, drives registered operands to an external
// combinational ALU, waits ALU_LATENCY cycles, then offers the captured
// result on a valid/ready output.
// Ports:
//   clk, rst            - clock, async active-high reset
//   in_data/valid/ready - command/operand byte stream
//   alu_a/alu_b/alu_s   - registered ALU operands and op select
//   alu_result          - combinational result from the ALU
//   out_data/valid/ready- result handshake
//   busy                - high whenever not IDLE
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_s,
    input  logic [7:0] alu_result,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [3:0] LAT_LAST = 4'(ALU_LATENCY - 1);

    seq_state_t r_state;
    seq_state_t w_next;

    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [2:0] r_alu_s;
    logic [7:0] r_out_data;
    logic [7:0] r_chain;
    logic [3:0] r_cnt;
    logic       r_unary;

    logic w_acc;
    logic w_chain;
    logic w_unary;
    logic w_exec_done;
    logic w_unused;

    // Bits [7:5] of a command byte carry no meaning.
    assign w_unused = ^in_data[7:5];

    assign w_chain     = in_data[CMD_CHAIN_BIT];
    assign w_unary     = in_data[CMD_UNARY_BIT];
    assign w_acc       = in_valid && in_ready;
    assign w_exec_done = (r_cnt == LAT_LAST);

    assign in_ready  = (r_state == S_IDLE) ||
                       (r_state == S_GET_A) ||
                       (r_state == S_GET_B);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_RESP);
    assign out_data  = r_out_data;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (!w_chain)
                        w_next = S_GET_A;
                    else if (!w_unary)
                        w_next = S_GET_B;
                    else
                        w_next = S_EXEC;
                end
            end
            S_GET_A: begin
                if (w_acc)
                    w_next = r_unary ? S_EXEC : S_GET_B;
            end
            S_GET_B: begin
                if (w_acc)
                    w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_exec_done)
                    w_next = S_RESP;
            end
            S_RESP: begin
                if (out_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_alu_a    <= 8'h00;
            r_alu_b    <= 8'h00;
            r_alu_s    <= 3'b000;
            r_out_data <= 8'h00;
            r_chain    <= 8'h00;
            r_cnt      <= 4'd0;
            r_unary    <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_alu_s <= in_data[CMD_OP_MSB:CMD_OP_LSB];
                        r_unary <= w_unary;
                        if (w_chain)
                            r_alu_a <= r_chain;
                        if (w_unary)
                            r_alu_b <= 8'h00;
                    end
                end
                S_GET_A: begin
                    if (w_acc)
                        r_alu_a <= in_data;
                end
                S_GET_B: begin
                    if (w_acc)
                        r_alu_b <= in_data;
                end
                S_EXEC: begin
                    if (w_exec_done) begin
                        r_out_data <= alu_result;
                        r_chain    <= alu_result;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                end
                default: begin
                end
            endcase
            // Counter restarts on every entry into EXEC.
            if (w_next == S_EXEC && r_state != S_EXEC)
                r_cnt <= 4'd0;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: one instance at ALU_LATENCY=1
// and one at ALU_LATENCY=4, each driving a behavioural 8-bit ALU.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst        [2];
    logic [7:0] in_data    [2];
    logic       in_valid   [2];
    logic       in_ready   [2];
    logic [7:0] alu_a      [2];
    logic [7:0] alu_b      [2];
    logic [2:0] alu_s      [2];
    logic [7:0] alu_result [2];
    logic [7:0] out_data   [2];
    logic       out_valid  [2];
    logic       out_ready  [2];
    logic       busy       [2];

    int errors = 0;
    int checks = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [2:0] s);
        logic [7:0] r;
        case (s)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = {a[6:0], 1'b0};
            default: r = {1'b0, a[7:1]};
        endcase
        return r;
    endfunction

    assign alu_result[0] = alu_f(alu_a[0], alu_b[0], alu_s[0]);
    assign alu_result[1] = alu_f(alu_a[1], alu_b[1], alu_s[1]);

    alu_op_sequencer #(.ALU_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst[0]),
        .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_s(alu_s[0]),
        .alu_result(alu_result[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .busy(busy[0])
    );

    alu_op_sequencer #(.ALU_LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst[1]),
        .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_s(alu_s[1]),
        .alu_result(alu_result[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .busy(busy[1])
    );

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
        int         lag;
        bit         gaps;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input int d, input logic [7:0] b,
                             input bit gaps);
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid[d] = 1'b0;
                in_data[d]  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_data[d]  = b;
        in_valid[d] = 1'b1;
        t = 0;
        while (!in_ready[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50)
            chk("in_ready timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_data[d]  = 8'($urandom);
    endtask

    task automatic run_cmd(input int d, input vec_t v);
        int lat;
        int exp_lat;
        logic [7:0] e;
        exp_lat = (d == 0) ? 1 : 4;
        sb_q.push_back(v.exp);
        send_byte(d, v.cmd, v.gaps);
        if (!v.cmd[3])
            send_byte(d, v.a, v.gaps);
        if (!v.cmd[4])
            send_byte(d, v.b, v.gaps);
        // Junk offered while not ready must be ignored.
        in_valid[d] = 1'b1;
        lat = 0;
        while (!out_valid[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        for (int k = 0; k < v.lag; k++) begin
            chk("held out_data", out_data[d], v.exp);
            chk("in_ready in RESP", in_ready[d], 0);
            @(posedge clk);
            #1;
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        chk("out_valid", out_valid[d], 1);
        if (sb_q.size() == 0) begin
            chk("scoreboard empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("out_data", out_data[d], e);
        end
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        chk("out_valid after xfer", out_valid[d], 0);
        chk("idle after xfer", {in_ready[d], busy[d]}, 2'b10);
    endtask

    task automatic chk_reset_outs(input int d, input string nm);
        chk(nm, {alu_a[d], alu_b[d], alu_s[d], out_data[d]}, 0);
        chk({nm, " flags"}, {out_valid[d], busy[d]}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            in_data[d]   = 8'h00;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
        end

        tv[0]  = '{8'h00, 8'h05, 8'h03, 8'h08, 0, 1'b0};
        tv[1]  = '{8'h08, 8'h00, 8'h02, 8'h0A, 0, 1'b0};
        tv[2]  = '{8'h1D, 8'h00, 8'h00, 8'hF5, 0, 1'b0};
        tv[3]  = '{8'h01, 8'h10, 8'h01, 8'h0F, 2, 1'b0};
        tv[4]  = '{8'h02, 8'hF0, 8'h3C, 8'h30, 0, 1'b0};
        tv[5]  = '{8'h03, 8'hF0, 8'h0C, 8'hFC, 1, 1'b0};
        tv[6]  = '{8'h04, 8'hFF, 8'h0F, 8'hF0, 0, 1'b0};
        tv[7]  = '{8'h16, 8'h81, 8'h00, 8'h02, 0, 1'b0};
        tv[8]  = '{8'hE7, 8'h80, 8'h55, 8'h40, 0, 1'b0};
        tv[9]  = '{8'h18, 8'h00, 8'h00, 8'h40, 0, 1'b0};
        tv[10] = '{8'h09, 8'h00, 8'h41, 8'hFF, 0, 1'b1};
        tv[11] = '{8'h00, 8'h05, 8'h03, 8'h08, 0, 1'b1};
        tv[12] = '{8'h15, 8'h0F, 8'h00, 8'hF0, 0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs(0, "reset dut1");
        chk_reset_outs(1, "reset dut4");
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        chk("in_ready after reset", {in_ready[0], in_ready[1]}, 2'b11);

        // Ready from consumer while idle must not start anything.
        out_ready[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("out_ready in IDLE", {out_valid[0], busy[0]}, 0);
        out_ready[0] = 1'b0;

        for (int i = 0; i < 13; i++)
            run_cmd(0, tv[i]);

        run_cmd(1, '{8'h01, 8'h10, 8'h01, 8'h0F, 3, 1'b0});

        // Reset mid-EXEC discards the pending result.
        send_byte(1, 8'h00, 1'b0);
        send_byte(1, 8'h11, 1'b0);
        send_byte(1, 8'h22, 1'b0);
        @(posedge clk);
        #2;
        rst[1] = 1'b1;
        #1;
        chk_reset_outs(1, "async reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        chk("in_ready after rst", in_ready[1], 1);
        begin
            bit seen;
            seen = 1'b0;
            repeat (8) begin
                @(posedge clk);
                #1;
                if (out_valid[1])
                    seen = 1'b1;
            end
            chk("no output after rst", seen, 0);
        end
        run_cmd(1, '{8'h08, 8'h00, 8'h07, 8'h07, 0, 1'b0});

        chk("scoreboard drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter ALU_LATENCY, default 1, range 1..15: cycles operands are held before the ALU result is captured.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_data  input  8  command/operand byte stream.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  byte accepted on edge where in_valid&&in_ready.
REQ-007 SHALL have port alu_a  output  8  ALU operand A, registered.
REQ-008 SHALL have port alu_b  output  8  ALU operand B, registered.
REQ-009 SHALL have port alu_s  output  3  ALU operation select, registered.
REQ-010 SHALL have port alu_result  input  8  combinational ALU result.
REQ-011 SHALL have port out_data  output  8  captured result.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 Command byte format SHALL be: [2:0] op, [3] CHAIN (A := last result, no A byte), [4] UNARY (B := 0, no B byte), [7:5] ignored.
REQ-016 States SHALL be IDLE, GET_A, GET_B, EXEC, RESP.
REQ-017 in_ready SHALL be high exactly in IDLE, GET_A, GET_B.
REQ-018 IDLE: on accepted byte, alu_s := op; if CHAIN, alu_a := chain_reg; next = GET_A if !CHAIN, else GET_B if !UNARY, else EXEC.
REQ-019 GET_A: on accept, alu_a := in_data; next = GET_B if !UNARY else EXEC.
REQ-020 GET_B: on accept, alu_b := in_data; next = EXEC.
REQ-021 UNARY SHALL load alu_b := 0 at command acceptance.
REQ-022 EXEC SHALL last exactly ALU_LATENCY cycles, counted by a 4-bit counter cleared on entry; alu_a/b/s stable throughout.
REQ-023 On the edge ending EXEC: out_data := alu_result, chain_reg := alu_result, state := RESP.
REQ-024 Latency: last byte accepted at edge N -> out_valid high from edge N+ALU_LATENCY.
REQ-025 RESP: out_valid high, out_data stable; on edge with out_ready high -> IDLE, out_valid low.
REQ-026 out_ready high on the first RESP cycle SHALL complete the transfer in that cycle (one-cycle RESP).
REQ-027 in_valid in EXEC/RESP SHALL be ignored; sender holds byte until in_ready.
REQ-028 out_ready outside RESP SHALL have no effect.
REQ-029 alu_a/b/s SHALL hold their last values in IDLE until overwritten.
REQ-030 chain_reg SHALL persist across commands; CHAIN as first command after reset uses 8'h00.

Reset
REQ-031 rst high SHALL immediately force state IDLE, alu_a/alu_b/out_data/chain_reg = 8'h00, alu_s = 3'b000, counter = 0, out_valid = 0, busy = 0, in_ready = 1 (after release).
REQ-032 Reset asserted mid-command or in RESP SHALL discard the partial command and pending result with no output transfer.

Structure
REQ-033 Shared package alu_pkg SHALL hold op encodings (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SHL=6, SHR=7), command-bit positions, and the state enum.
REQ-034 No sub-module; alu_8bits instantiated beside this block at top level, connected via alu_* ports.

Verification
REQ-035 ALU_LATENCY=1, bytes 8'h00,8'h05,8'h03 (ADD) -> out_data=8'h08, out_valid one edge after B accepted.
REQ-036 Then CHAIN ADD 8'h08,B=8'h02 -> out_data=8'h0A; no A byte consumed.
REQ-037 CHAIN|UNARY NOT (8'h1D) after previous -> EXEC entered directly, out_data=8'hF5.
REQ-038 ALU_LATENCY=4, SUB 8'h10,8'h01 with out_ready low 3 cycles -> out_data=8'h0F held, in_ready low until accepted.
REQ-039 in_valid toggled randomly (gaps) during GET_A/GET_B -> result identical to gapless case.
REQ-040 rst pulse during EXEC -> out_valid never asserts, all outputs 0; next CHAIN ADD B=8'h07 -> 8'h07.
